// File: rtl/axi_st_rd_ctrl.sv
// ---------------------------------------------------------------------------
// axi_st_rd_ctrl
//
// Receive-side valid/ready controller for an AXI-Stream link feeding a
// write-side FIFO. A 2-entry skid buffer lets axist_rdy come straight from a
// flop while the FIFO applies backpressure. The block also counts beats and
// packets, and flags a transmitter that withdraws valid before a handshake.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   rx_en         receive enable; low blocks new acceptance
//   axist_valid   transmitter beat valid
//   axist_data    beat payload
//   axist_last    end-of-packet marker
//   axist_rdy     registered ready back to the transmitter
//   fifo_full     downstream FIFO full
//   fifo_wren     FIFO write strobe (skid head is valid and FIFO not full)
//   fifo_wdata    {last, data} of the skid head
//   beat_cnt      accepted beats, saturating
//   pkt_cnt       accepted beats with last set, saturating
//   err_vld_drop  sticky "valid dropped without acceptance" flag
// ---------------------------------------------------------------------------
module axi_st_rd_ctrl #(
    parameter int DATA_WIDTH = 512,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_en,
    input  logic                  axist_valid,
    input  logic [DATA_WIDTH-1:0] axist_data,
    input  logic                  axist_last,
    output logic                  axist_rdy,
    input  logic                  fifo_full,
    output logic                  fifo_wren,
    output logic [DATA_WIDTH:0]   fifo_wdata,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic                  err_vld_drop
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [1:0]          occ;
    logic [1:0]          occ_next;
    logic [1:0]          tail_pos;
    logic [DATA_WIDTH:0] skid_head;
    logic [DATA_WIDTH:0] skid_tail;
    logic                accept;
    logic                drain;
    logic                valid_q;
    logic                rdy_q;

    assign accept     = axist_valid & axist_rdy;
    assign drain      = (occ != 2'd0) & ~fifo_full;
    assign fifo_wren  = drain;
    assign fifo_wdata = skid_head;

    // tail_pos is where an incoming beat lands once this cycle's drain has
    // shifted the queue forward; occ=1 with a drain puts the new beat at head.
    always_comb begin
        occ_next = occ + {1'b0, accept} - {1'b0, drain};
        tail_pos = occ - {1'b0, drain};
    end

    // Occupancy and ready. Ready looks at next-cycle occupancy so that a beat
    // accepted while the registered ready is still high always has a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= 2'd0;
            axist_rdy <= 1'b0;
        end else begin
            occ       <= occ_next;
            axist_rdy <= rx_en & (occ_next <= 2'd1);
        end
    end

    // Skid storage is pure datapath; occ alone says which entries are live,
    // so the payload registers need no reset.
    always_ff @(posedge clk) begin
        if (drain) begin
            skid_head <= skid_tail;
        end
        if (accept) begin
            if (tail_pos == 2'd0) begin
                skid_head <= {axist_last, axist_data};
            end else begin
                skid_tail <= {axist_last, axist_data};
            end
        end
    end

    // Saturating beat and packet counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else begin
            if (accept && (beat_cnt != CNT_MAX)) begin
                beat_cnt <= beat_cnt + CNT_ONE;
            end
            if (accept && axist_last && (pkt_cnt != CNT_MAX)) begin
                pkt_cnt <= pkt_cnt + CNT_ONE;
            end
        end
    end

    // Protocol monitor: valid seen last cycle without ready, gone this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            rdy_q        <= 1'b0;
            err_vld_drop <= 1'b0;
        end else begin
            valid_q <= axist_valid;
            rdy_q   <= axist_rdy;
            if (valid_q && !rdy_q && !axist_valid) begin
                err_vld_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_st_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_st_rd_ctrl
//
// Self-checking bench for axi_st_rd_ctrl. Accepted beats are pushed into a
// scoreboard queue and popped when the FIFO write strobe fires, so order,
// loss and duplication are all caught. Directed steps cover reset, streaming,
// backpressure, rx_en gating, the protocol-error flag, asynchronous reset
// with a full skid and counter saturation (CNT_WIDTH=4).
// ---------------------------------------------------------------------------
module tb_axi_st_rd_ctrl;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          rx_en;
    logic          axist_valid;
    logic [DW-1:0] axist_data;
    logic          axist_last;
    logic          axist_rdy;
    logic          fifo_full;
    logic          fifo_wren;
    logic [DW:0]   fifo_wdata;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] pkt_cnt;
    logic          err_vld_drop;

    int checks     = 0;
    int errors     = 0;
    int wren_total = 0;
    int wren_mark  = 0;

    logic [DW:0] sb[$];

    axi_st_rd_ctrl #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_en       (rx_en),
        .axist_valid (axist_valid),
        .axist_data  (axist_data),
        .axist_last  (axist_last),
        .axist_rdy   (axist_rdy),
        .fifo_full   (fifo_full),
        .fifo_wren   (fifo_wren),
        .fifo_wdata  (fifo_wdata),
        .beat_cnt    (beat_cnt),
        .pkt_cnt     (pkt_cnt),
        .err_vld_drop(err_vld_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, landing 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat and hold it until a handshake edge, with a cycle budget.
    task automatic apply_stimulus(input logic [DW-1:0] d, input logic l);
        logic ok;
        ok          = 1'b0;
        axist_valid = 1'b1;
        axist_data  = d;
        axist_last  = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = axist_rdy;
            @(posedge clk);
            #1;
        end
        check_output("handshake_timeout", {31'd0, ok}, 32'd1);
    endtask

    // Scoreboard monitor on the falling edge: pop for this cycle's write
    // (which only reflects earlier accepts), then push this cycle's accept.
    always @(negedge clk) begin
        logic [DW:0] exp_beat;
        if (!rst_n) begin
            sb.delete();
        end else begin
            checks++;
            assert (dut.occ <= 2'd2)
            else begin
                errors++;
                $error("[TB] FAIL occ_bound observed=%0d expected<=2", dut.occ);
            end
            if (fifo_wren) begin
                wren_total++;
                checks++;
                assert (sb.size() != 0)
                else begin
                    errors++;
                    $error("[TB] FAIL unexpected_wren observed=%0h expected=no_write", fifo_wdata);
                end
                if (sb.size() != 0) begin
                    exp_beat = sb.pop_front();
                    checks++;
                    assert (fifo_wdata === exp_beat)
                    else begin
                        errors++;
                        $error("[TB] FAIL wdata observed=%0h expected=%0h", fifo_wdata, exp_beat);
                    end
                end
            end
            if (axist_valid && axist_rdy) begin
                sb.push_back({axist_last, axist_data});
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        rx_en       = 1'b1;
        axist_valid = 1'b0;
        axist_data  = '0;
        axist_last  = 1'b0;
        fifo_full   = 1'b0;

        // Reset state.
        #2;
        check_output("rst_rdy", {31'd0, axist_rdy}, 32'd0);
        check_output("rst_wren", {31'd0, fifo_wren}, 32'd0);
        check_output("rst_beat", {28'd0, beat_cnt}, 32'd0);
        check_output("rst_pkt", {28'd0, pkt_cnt}, 32'd0);
        check_output("rst_err", {31'd0, err_vld_drop}, 32'd0);
        #10 rst_n = 1'b1;
        step(1);
        check_output("rdy_first_edge", {31'd0, axist_rdy}, 32'd1);

        // Back-to-back stream of 8 beats, last on beat 7.
        apply_stimulus(32'd0, 1'b0);
        check_output("wren_lag_one", {31'd0, fifo_wren}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            apply_stimulus(i, (i == 7));
        end
        axist_valid = 1'b0;
        axist_last  = 1'b0;
        step(3);
        check_output("stream_beat", {28'd0, beat_cnt}, 32'd8);
        check_output("stream_pkt", {28'd0, pkt_cnt}, 32'd1);
        check_output("stream_wren_total", wren_total, 32'd8);

        // FIFO full: skid fills to two, ready drops, then drains in order.
        fifo_full = 1'b1;
        apply_stimulus(32'd100, 1'b0);
        check_output("full_rdy_occ1", {31'd0, axist_rdy}, 32'd1);
        apply_stimulus(32'd101, 1'b0);
        check_output("full_rdy_low", {31'd0, axist_rdy}, 32'd0);
        axist_valid = 1'b1;
        axist_data  = 32'd102;
        axist_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_output("full_rdy_held", {31'd0, axist_rdy}, 32'd0);
        end
        check_output("full_beat_held", {28'd0, beat_cnt}, 32'd10);
        fifo_full = 1'b0;
        #1;
        check_output("full_clear_wren", {31'd0, fifo_wren}, 32'd1);
        apply_stimulus(32'd102, 1'b1);
        axist_valid = 1'b0;
        axist_last  = 1'b0;
        step(3);
        check_output("full_beat", {28'd0, beat_cnt}, 32'd11);
        check_output("full_pkt", {28'd0, pkt_cnt}, 32'd2);
        check_output("full_wren_total", wren_total, 32'd11);
        check_output("full_sb_empty", sb.size(), 32'd0);

        // rx_en low with one beat buffered.
        fifo_full = 1'b1;
        apply_stimulus(32'd200, 1'b0);
        axist_valid = 1'b0;
        rx_en       = 1'b0;
        step(1);
        check_output("rxen_rdy_low", {31'd0, axist_rdy}, 32'd0);
        check_output("rxen_wren_blocked", {31'd0, fifo_wren}, 32'd0);
        fifo_full = 1'b0;
        #1;
        check_output("rxen_drain_wren", {31'd0, fifo_wren}, 32'd1);
        axist_valid = 1'b1;
        axist_data  = 32'd201;
        step(2);
        check_output("rxen_no_accept", {28'd0, beat_cnt}, 32'd12);
        check_output("rxen_drained", wren_total, 32'd12);
        rx_en = 1'b1;
        step(1);
        check_output("rxen_rdy_back", {31'd0, axist_rdy}, 32'd1);
        apply_stimulus(32'd201, 1'b0);
        axist_valid = 1'b0;
        step(2);
        check_output("rxen_beat", {28'd0, beat_cnt}, 32'd13);
        check_output("rxen_err_clear", {31'd0, err_vld_drop}, 32'd0);

        // Valid withdrawn while ready is low.
        rx_en = 1'b0;
        step(1);
        check_output("err_rdy_low", {31'd0, axist_rdy}, 32'd0);
        axist_valid = 1'b1;
        axist_data  = 32'd250;
        step(1);
        axist_valid = 1'b0;
        step(1);
        check_output("err_set", {31'd0, err_vld_drop}, 32'd1);
        step(3);
        check_output("err_sticky", {31'd0, err_vld_drop}, 32'd1);
        check_output("err_beat_same", {28'd0, beat_cnt}, 32'd13);
        rx_en = 1'b1;
        step(1);

        // Asynchronous reset mid-cycle with the skid full.
        fifo_full = 1'b1;
        apply_stimulus(32'd300, 1'b0);
        apply_stimulus(32'd301, 1'b0);
        axist_valid = 1'b0;
        check_output("arst_pre_rdy", {31'd0, axist_rdy}, 32'd0);
        #2;
        fifo_full = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_output("arst_rdy", {31'd0, axist_rdy}, 32'd0);
        check_output("arst_wren", {31'd0, fifo_wren}, 32'd0);
        check_output("arst_beat", {28'd0, beat_cnt}, 32'd0);
        check_output("arst_pkt", {28'd0, pkt_cnt}, 32'd0);
        check_output("arst_err", {31'd0, err_vld_drop}, 32'd0);
        wren_mark = wren_total;
        step(2);
        #3 rst_n = 1'b1;
        step(3);
        check_output("arst_no_stale", wren_total, wren_mark);
        check_output("arst_rdy_back", {31'd0, axist_rdy}, 32'd1);

        // 20 single-beat packets saturate the 4-bit counters.
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(32'h400 + i, 1'b1);
        end
        axist_valid = 1'b0;
        axist_last  = 1'b0;
        step(3);
        check_output("sat_beat", {28'd0, beat_cnt}, 32'd15);
        check_output("sat_pkt", {28'd0, pkt_cnt}, 32'd15);
        check_output("sat_wren_total", wren_total, wren_mark + 20);
        check_output("final_sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_st_rd_ctrl.md
Name: axi_st_rd_ctrl

Overview:
- AXI-ST receive-side valid/ready controller.
- Accepts beats from an AXI-ST link and writes them into a downstream write-side FIFO.
- Owns a 2-entry skid buffer so `axist_rdy` can be a registered output while the FIFO applies backpressure.
- Counts beats and packets, and flags the protocol violation of valid dropping without acceptance.

Parameters:
- DATA_WIDTH, 512, width of axist_data and fifo_wdata.
- CNT_WIDTH, 16, width of the beat and packet counters (saturating).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_en  input  1  receive enable; low blocks new acceptance.
- axist_valid  input  1  transmitter beat valid.
- axist_data  input  DATA_WIDTH  beat payload.
- axist_last  input  1  end-of-packet marker.
- axist_rdy  output  1  registered ready to transmitter.
- fifo_full  input  1  downstream FIFO full.
- fifo_wren  output  1  FIFO write strobe.
- fifo_wdata  output  DATA_WIDTH+1  {last, data} of the skid head.
- beat_cnt  output  CNT_WIDTH  accepted beats, saturating.
- pkt_cnt  output  CNT_WIDTH  accepted beats with last=1, saturating.
- err_vld_drop  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, sync release):
  - axist_rdy=0, fifo_wren=0 (skid empty).
  - beat_cnt=0, pkt_cnt=0, err_vld_drop=0.
  - Skid occupancy occ=0.
- Reset asserted mid-operation discards skid contents immediately.
- accept = axist_valid & axist_rdy. On accept, {axist_last, axist_data} is pushed to the skid tail.
- drain = (occ!=0) & ~fifo_full.
  - fifo_wren = drain; it is combinational from registered occ and fifo_full.
  - fifo_wdata = skid head.
- Latency: a beat accepted in cycle t into an empty skid with fifo_full=0 appears on fifo_wren/fifo_wdata in cycle t+1.
- occ_next = occ + accept − drain, range 0..2.
  - Accept and drain in the same cycle leaves occ unchanged.
  - FIFO order is preserved; with occ=1, the head drains while the new beat becomes head.
- axist_rdy <= rx_en & (occ_next <= 1) at every clock.
  - This guarantees that a beat accepted in the cycle after rdy was computed never overflows the skid.
  - First rdy=1 occurs on the first clock edge after reset release, if rx_en=1.
- Sustained throughput: 1 beat/cycle while fifo_full=0 (occ stays 0 or 1, rdy stays 1).
- fifo_full held: the skid fills to 2 and rdy drops.
  - Exactly one more beat may be accepted after the first full cycle.
  - rdy reasserts the cycle after occ_next falls to ≤1.
- rx_en low:
  - rdy drops on the next edge; beats already in the skid still drain.
  - A beat accepted in the same cycle rdy is sampled high is still accepted.
- Counters:
  - beat_cnt increments on accept.
  - pkt_cnt increments on accept & axist_last.
  - Both saturate at all-ones (no wrap).
- Protocol check (axist_valid_q and rdy_q are the previous-cycle values):
  - err_vld_drop is set when axist_valid_q=1 & rdy_q=0 & axist_valid=0 (valid withdrawn before handshake).
  - Sticky until reset.
  - Payload stability while stalled is not checked.
- occ never exceeds 2. Overflow is impossible by construction, and the bench asserts it.

Test Plan:
- Reset release, rx_en=1, fifo_full=0, 8 back-to-back beats data=0..7, last on beat 7 -> rdy high from cycle 1; fifo_wren for 8 consecutive cycles, each lagging accept by 1; wdata order 0..7; beat_cnt=8, pkt_cnt=1.
- Streaming beats, fifo_full=1 for 5 cycles -> occ reaches 2; exactly 2 beats buffered; rdy low within 1 cycle of occ_next=2; after full clears, skid drains in order with no loss or duplicate; rdy back high 1 cycle after drain.
- rx_en deasserted mid-stream with occ=1 -> rdy low next edge; the buffered beat is written; no accept while rdy=0; rx_en=1 resumes with rdy high next edge.
- Valid asserted while rdy=0, then dropped before rdy returns -> err_vld_drop=1 and held; beat_cnt unchanged.
- Async rst_n pulse mid-clock with occ=2 -> rdy, fifo_wren, counters and err clear immediately without a clock edge; no stale beat written after release.
- CNT_WIDTH=4, 20 single-beat packets -> beat_cnt=15, pkt_cnt=15 (saturated, no wrap).
